// File: rtl/exp_pkg.sv
// exp_pkg: shared FSM states and elaboration-time constant helpers for the exponential unit
package exp_pkg;
  typedef enum logic [1:0] {IDLE, MULX, MULC, FIN} state_t;
  // Accumulator width: integer field, result fraction and guard bits
  function automatic int acc_w(input int int_w, input int frac_w, input int guard_w);
    return int_w + frac_w + guard_w;
  endfunction
  // 1.0 in a format with f fraction bits
  function automatic logic [63:0] one_val(input int f);
    return 64'd1 << f;
  endfunction
  // round(2^n / k), round-to-nearest with ties up
  function automatic logic [63:0] coef_round(input int n, input int k);
    return ((64'd1 << n) + 64'(k / 2)) / 64'(k);
  endfunction
endpackage

// File: rtl/exp_coef_rom.sv
// exp_coef_rom: combinational 1/k coefficient table in 0.CW format, built at elaboration
module exp_coef_rom
  import exp_pkg::*;
#(
  parameter int NTERMS = 8,
  parameter int CW     = 20,
  parameter int KW     = $clog2(NTERMS + 1)
) (
  input  logic [KW-1:0] i_k,
  output logic [CW-1:0] o_c
);
  // k=0 and k=1 read all-ones; the top bypasses the multiply for k=1
  always_comb begin
    o_c = '1;
    for (int i = 2; i <= NTERMS; i++) o_c = (i_k == KW'(i)) ? CW'(coef_round(CW, i)) : o_c;
  end
endmodule

// File: rtl/exponential_param.sv
// exponential_param: iterative Horner-form Taylor evaluation of e^x / e^-x with one shared multiplier
module exponential_param
  import exp_pkg::*;
#(
  parameter int FRAC_W  = 16,
  parameter int INT_W   = 2,
  parameter int NTERMS  = 8,
  parameter int GUARD_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [FRAC_W-1:0] x,
  output logic              busy,
  output logic              done,
  output logic [INT_W-1:0]  intpart,
  output logic [FRAC_W-1:0] fracpart
);
  localparam int F  = FRAC_W + GUARD_W;
  localparam int AW = acc_w(INT_W, FRAC_W, GUARD_W);
  localparam int KW = $clog2(NTERMS + 1);
  localparam int PW = AW + F;
  localparam logic [AW-1:0] ONE = AW'(one_val(F));

  state_t            r_state;
  logic [AW-1:0]     r_acc, r_p;
  logic [KW-1:0]     r_k;
  logic [FRAC_W-1:0] r_x;
  logic              r_mode;
  logic [F-1:0]      w_c;
  logic [AW-1:0]     w_ma, w_mb, w_prod_t, w_term;
  logic [PW-1:0]     w_prod;

  exp_coef_rom #(.NTERMS(NTERMS), .CW(F), .KW(KW)) u_rom (.i_k(r_k), .o_c(w_c));

  // x is widened to F fraction bits so both products drop the same F LSBs
  assign w_ma     = (r_state == MULX) ? r_acc : r_p;
  assign w_mb     = (r_state == MULX) ? (AW'(r_x) << GUARD_W) : AW'(w_c);
  assign w_prod   = PW'(w_ma) * PW'(w_mb);
  assign w_prod_t = AW'(w_prod >> F);
  assign w_term   = (r_k == KW'(1)) ? r_p : w_prod_t;

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_p      <= '0;
      r_k      <= '0;
      r_x      <= '0;
      r_mode   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      intpart  <= '0;
      fracpart <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_x     <= x;
          r_mode  <= mode;
          r_acc   <= ONE;
          r_k     <= KW'(NTERMS);
          busy    <= 1'b1;
          r_state <= MULX;
        end
        MULX: begin
          r_p     <= w_prod_t;
          r_state <= MULC;
        end
        MULC: begin
          r_acc   <= r_mode ? ONE - w_term : ONE + w_term;
          r_k     <= (r_k == KW'(1)) ? r_k : r_k - KW'(1);
          r_state <= (r_k == KW'(1)) ? FIN : MULX;
        end
        FIN: begin
          intpart  <= r_acc[AW-1 -: INT_W];
          fracpart <= r_acc[F-1 -: FRAC_W];
          done     <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_exponential_param.sv
// tb_exponential_param: directed-vector self-checking bench for exponential_param
module tb_exponential_param;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] x = '0;
  logic        busy, done;
  logic [1:0]  intpart;
  logic [15:0] fracpart;
  int checks = 0;
  int errors = 0;

  exponential_param dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x),
    .busy(busy), .done(done), .intpart(intpart), .fracpart(fracpart)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done; returns in the done cycle
  task automatic do_op(input logic m, input logic [15:0] xv, output int lat, output int bcnt,
                       output logic [1:0] ip, output logic [15:0] fp);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    x     = xv;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = 0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (done) lat = n;
    end
    ip = intpart;
    fp = fracpart;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (intpart !== 2'd0) begin errors++; $display("FAIL reset_int got %0h want 0", intpart); end
    checks++; if (fracpart !== 16'h0) begin errors++; $display("FAIL reset_frac got %0h want 0", fracpart); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_zero;
    int lat, bcnt; logic [1:0] ip; logic [15:0] fp;
    do_op(1'b0, 16'h0000, lat, bcnt, ip, fp);
    checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency got %0d want 17", lat); end
    checks++; if (bcnt !== 17) begin errors++; $display("FAIL zero_busy_cycles got %0d want 17", bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy_overlap got %0b want 0", busy); end
    checks++; if (ip !== 2'd1) begin errors++; $display("FAIL zero_int got %0d want 1", ip); end
    checks++; if (fp !== 16'h0000) begin errors++; $display("FAIL zero_frac got %h want 0000", fp); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %0b want 0", done); end
    checks++; if (fracpart !== 16'h0000 || intpart !== 2'd1) begin errors++; $display("FAIL zero_hold got %0d.%h want 1.0000", intpart, fracpart); end
    do_op(1'b1, 16'h0000, lat, bcnt, ip, fp);
    checks++; if (ip !== 2'd1 || fp !== 16'h0000) begin errors++; $display("FAIL neg_zero got %0d.%h want 1.0000", ip, fp); end
  endtask

  task automatic test_values;
    int lat, bcnt, d; logic [1:0] ip; logic [15:0] fp;
    do_op(1'b0, 16'h8000, lat, bcnt, ip, fp);
    d = int'(fp) - 'hA613;
    checks++; if (ip !== 2'd1 || d < -3 || d > 3) begin errors++; $display("FAIL exp_half got %0d.%h want 1.a613+-3", ip, fp); end
    do_op(1'b0, 16'hFFFF, lat, bcnt, ip, fp);
    d = int'(fp) - 'hB7DF;
    checks++; if (ip !== 2'd2 || d < -3 || d > 3) begin errors++; $display("FAIL exp_one got %0d.%h want 2.b7df+-3", ip, fp); end
    do_op(1'b1, 16'h8000, lat, bcnt, ip, fp);
    d = int'(fp) - 'h9B46;
    checks++; if (ip !== 2'd0 || d < -3 || d > 3) begin errors++; $display("FAIL negexp_half got %0d.%h want 0.9b46+-3", ip, fp); end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, d; logic [1:0] ip; logic [15:0] fp;
    do_op(1'b1, 16'hFFFF, lat, bcnt, ip, fp);
    d = int'(fp) - 'h5E2D;
    checks++; if (ip !== 2'd0 || d < -3 || d > 3) begin errors++; $display("FAIL negexp_one got %0d.%h want 0.5e2d+-3", ip, fp); end
    do_op(1'b0, 16'h4000, lat, bcnt, ip, fp);
    d = int'(fp) - 'h48B5;
    checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_latency got %0d want 17", lat); end
    checks++; if (ip !== 2'd1 || d < -3 || d > 3) begin errors++; $display("FAIL exp_quarter got %0d.%h want 1.48b5+-3", ip, fp); end
  endtask

  task automatic test_start_ignored;
    int dcnt, lat, d; logic bz;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; x = 16'h8000;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; lat = 0; bz = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin start = 1'b1; x = 16'hFFFF; mode = 1'b1; end
      if (n == 6) begin start = 1'b0; x = 16'h1234; end
      @(posedge clk); #1;
      if (done) begin dcnt++; if (lat == 0) lat = n; d = int'(fracpart) - 'hA613; end
      if (n > 18 && busy) bz = 1'b1;
    end
    checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency got %0d want 17", lat); end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dcnt); end
    checks++; if (bz !== 1'b0) begin errors++; $display("FAIL ignore_restart got busy %0b want 0", bz); end
    checks++; if (intpart !== 2'd1 || d < -3 || d > 3) begin errors++; $display("FAIL ignore_result got %0d.%h want 1.a613+-3", intpart, fracpart); end
    mode = 1'b0; x = 16'h0000;
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dseen; logic [1:0] ip; logic [15:0] fp;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; x = 16'h8000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_flags got busy %0b done %0b want 0 0", busy, done); end
    checks++; if (intpart !== 2'd0 || fracpart !== 16'h0) begin errors++; $display("FAIL midrst_result got %0d.%h want 0.0000", intpart, fracpart); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    dseen = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) dseen++; end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d active cycles want 0", dseen); end
    do_op(1'b0, 16'h0000, lat, bcnt, ip, fp);
    checks++; if (lat !== 17) begin errors++; $display("FAIL midrst_latency got %0d want 17", lat); end
    checks++; if (ip !== 2'd1 || fp !== 16'h0000) begin errors++; $display("FAIL midrst_result_after got %0d.%h want 1.0000", ip, fp); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_values;
    test_back_to_back;
    test_start_ignored;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
